// File: rtl/bit8_mux_arbiter_pkg.sv
// Shared definitions for the two-port 8-bit round-robin arbiter.
//   state_e       : FSM state encoding (IDLE / G0 / G1)
//   MAX_BURST_DEF : default beat limit per grant
//   CNT_W_DEF     : default beat-counter width (must hold MAX_BURST)
package bit8_mux_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

  localparam int MAX_BURST_DEF = 4;
  localparam int CNT_W_DEF     = 3;

endpackage

// File: rtl/bit8_mux_arbiter_if.sv
// Bundle of the producer, grant and consumer-side handshake signals.
//   req0/req1, in0/in1, last0/last1 : producer requests, data and end-of-burst
//   gnt0/gnt1                       : registered grants back to the producers
//   out_data/out_src/out_valid      : registered shared-bus beat
//   out_ready                       : consumer accept
// Modport slave is the arbiter; modport master is the producer/consumer side.
interface bit8_mux_arbiter_if;
  logic       req0, req1;
  logic [7:0] in0, in1;
  logic       last0, last1;
  logic       gnt0, gnt1;
  logic [7:0] out_data;
  logic       out_src;
  logic       out_valid;
  logic       out_ready;

  modport slave (
    input  req0, req1, in0, in1, last0, last1, out_ready,
    output gnt0, gnt1, out_data, out_src, out_valid
  );

  modport master (
    output req0, req1, in0, in1, last0, last1, out_ready,
    input  gnt0, gnt1, out_data, out_src, out_valid
  );
endinterface

// File: rtl/bit8_2to1mux.sv
// Plain 8-bit 2:1 multiplexer.
//   in1_i : passed when sel_i = 0
//   in2_i : passed when sel_i = 1
//   sel_i : select
//   out_o : selected operand
module bit8_2to1mux (
  input  logic [7:0] in1_i,
  input  logic [7:0] in2_i,
  input  logic       sel_i,
  output logic [7:0] out_o
);
  assign out_o = sel_i ? in2_i : in1_i;
endmodule

// File: rtl/bit8_mux_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit output between two
// requesters, with a per-grant beat limit and a one-entry valid/ready
// output stage.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : arbiter side of bit8_mux_arbiter_if (requests in, grants and
//           output beat out, out_ready in)
module bit8_mux_arbiter
  import bit8_mux_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  bit8_mux_arbiter_if.slave  bus
);

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [7:0]         data_q, data_d;
  logic               src_q, src_d;
  logic               vld_q, vld_d;

  logic [7:0]         mux_out;
  logic               sel;
  logic               req_g, last_g, own_req, oth_req;
  logic               acc, cap_rel, rel;

  // sel doubles as the index of the current grant holder
  assign sel = (state_q == G1);

  bit8_2to1mux u_mux (
    .in1_i (bus.in0),
    .in2_i (bus.in1),
    .sel_i (sel),
    .out_o (mux_out)
  );

  assign req_g   = ((state_q == G0) & bus.req0) | ((state_q == G1) & bus.req1);
  assign last_g  = ((state_q == G0) & bus.last0) | ((state_q == G1) & bus.last1);
  assign own_req = sel ? bus.req1 : bus.req0;
  assign oth_req = sel ? bus.req0 : bus.req1;

  // a beat moves only when the output slot is empty or draining this edge
  assign acc     = req_g & (~vld_q | bus.out_ready);
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign cap_rel = acc & (last_g | (cnt_inc == CNT_W'(MAX_BURST)));
  // a dropped req releases without taking a beat, even if last is high
  assign rel     = (state_q != IDLE) & (~req_g | cap_rel);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 & bus.req1) state_d = ptr_q ? G1 : G0;
        else if (bus.req0)       state_d = G0;
        else if (bus.req1)       state_d = G1;
      end
      G0, G1: begin
        if (rel) begin
          ptr_d = ~sel;
          cnt_d = '0;
          // the other side goes first; a still-requesting holder is re-granted
          if (oth_req)      state_d = sel ? G0 : G1;
          else if (own_req) state_d = state_q;
          else              state_d = IDLE;
        end else if (acc) begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    src_d  = src_q;
    vld_d  = vld_q;
    if (acc) begin
      data_d = mux_out;
      src_d  = sel;
      vld_d  = 1'b1;
    end else if (vld_q & bus.out_ready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      src_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      src_q   <= src_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.gnt0      = (state_q == G0);
  assign bus.gnt1      = (state_q == G1);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_bit8_mux_arbiter.sv
module tb_bit8_mux_arbiter;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bit8_mux_arbiter_if bus ();

  bit8_mux_arbiter #(.MAX_BURST(MB), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;

  // reference model: who owns the bus, how many beats taken, held beat
  int         m_owner;
  int         m_taken;
  int         m_ptr;
  logic       m_vld;
  logic       m_src;
  logic [7:0] m_data;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    logic       r[2];
    logic       l[2];
    logic [7:0] d[2];
    int         own, oth;
    logic       rq_own, acc;
    if (!rst_n) begin
      m_owner = -1; m_taken = 0; m_ptr = 0;
      m_vld = 1'b0; m_src = 1'b0; m_data = 8'h00;
      return;
    end
    r[0] = bus.req0;  r[1] = bus.req1;
    l[0] = bus.last0; l[1] = bus.last1;
    d[0] = bus.in0;   d[1] = bus.in1;
    own    = m_owner;
    rq_own = (own >= 0) && r[own];
    acc    = rq_own && (!m_vld || bus.out_ready);
    if (acc) begin
      m_data = d[own]; m_src = own[0]; m_vld = 1'b1;
    end else if (m_vld && bus.out_ready) begin
      m_vld = 1'b0;
    end
    if (own < 0) begin
      if (r[0] && r[1]) m_owner = m_ptr;
      else if (r[0])    m_owner = 0;
      else if (r[1])    m_owner = 1;
    end else if (!rq_own || (acc && (l[own] || m_taken + 1 == MB))) begin
      oth     = 1 - own;
      m_ptr   = oth;
      m_taken = 0;
      if (r[oth])      m_owner = oth;
      else if (r[own]) m_owner = own;
      else             m_owner = -1;
    end else if (acc) begin
      m_taken++;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check("model", 32'({bus.gnt0, bus.gnt1, bus.out_valid, bus.out_src, bus.out_data}),
          32'({m_owner == 0, m_owner == 1, m_vld, m_src, m_data}));
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.in0 = 8'h00; bus.in1 = 8'h00;
    bus.last0 = 1'b0; bus.last1 = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       rst, req0, req1, last0, last1, rdy;
    logic [7:0] in0, in1;
    logic       g0, g1, ov, os;
    logic [7:0] od;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [7:0] got8[$];
    int         t0, t1;
    logic       tk0, tk1, rdy, prev_v;
    logic [7:0] prev_d;

    idle_inputs();
    rst_n = 1'b0;

    // rst req0 req1 last0 last1 rdy in0 in1 | g0 g1 ov os od
    tbl[0]  = '{0,0,0,0,0,1,8'h00,8'h00, 0,0,0,0,8'h00};
    tbl[1]  = '{1,1,0,0,0,1,8'h11,8'h00, 1,0,0,0,8'h00};
    tbl[2]  = '{1,1,0,0,0,1,8'h11,8'h00, 1,0,1,0,8'h11};
    tbl[3]  = '{1,1,0,0,0,1,8'h22,8'h00, 1,0,1,0,8'h22};
    tbl[4]  = '{1,1,0,1,0,1,8'h33,8'h00, 1,0,1,0,8'h33};
    tbl[5]  = '{1,0,0,0,0,1,8'h00,8'h00, 0,0,0,0,8'h33};
    tbl[6]  = '{0,0,0,0,0,1,8'h00,8'h00, 0,0,0,0,8'h00};
    tbl[7]  = '{1,1,1,0,0,1,8'h40,8'h50, 1,0,0,0,8'h00};
    tbl[8]  = '{1,1,1,1,0,1,8'h40,8'h50, 0,1,1,0,8'h40};
    tbl[9]  = '{1,1,1,0,1,1,8'h41,8'h50, 1,0,1,1,8'h50};
    tbl[10] = '{1,1,1,1,0,1,8'h41,8'h51, 0,1,1,0,8'h41};
    tbl[11] = '{1,0,0,0,0,1,8'h00,8'h00, 0,0,0,0,8'h41};
    tbl[12] = '{1,1,1,0,0,1,8'h42,8'h52, 1,0,0,0,8'h41};
    tbl[13] = '{1,0,0,0,0,1,8'h00,8'h00, 0,0,0,0,8'h41};
    tbl[14] = '{1,0,1,0,0,1,8'h00,8'h77, 0,1,0,0,8'h41};
    tbl[15] = '{1,1,0,0,0,1,8'h60,8'h77, 1,0,0,0,8'h41};
    tbl[16] = '{1,0,0,0,0,1,8'h00,8'h00, 0,0,0,0,8'h41};

    for (int i = 0; i < 17; i++) begin
      rst_n = tbl[i].rst;
      bus.req0 = tbl[i].req0;   bus.req1 = tbl[i].req1;
      bus.last0 = tbl[i].last0; bus.last1 = tbl[i].last1;
      bus.in0 = tbl[i].in0;     bus.in1 = tbl[i].in1;
      bus.out_ready = tbl[i].rdy;
      step();
      check($sformatf("vec%0d", i),
            32'({bus.gnt0, bus.gnt1, bus.out_valid, bus.out_src, bus.out_data}),
            32'({tbl[i].g0, tbl[i].g1, tbl[i].ov, tbl[i].os, tbl[i].od}));
    end

    // burst cap: req1 streams without last, req0 joins at cycle 2
    do_reset();
    t0 = 0; t1 = 0;
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 8'(8'hB0 + k)});
    exp_q.push_back({1'b0, 8'hC0});
    exp_q.push_back({1'b0, 8'hC1});
    for (int k = 4; k < 9; k++) exp_q.push_back({1'b1, 8'(8'hB0 + k)});
    for (int c = 0; c < 16; c++) begin
      bus.req1 = (c <= 11); bus.in1 = 8'(8'hB0 + t1); bus.last1 = 1'b0;
      bus.req0 = (c >= 2) && (t0 < 2); bus.in0 = 8'(8'hC0 + t0); bus.last0 = (t0 == 1);
      bus.out_ready = 1'b1;
      tk1 = bus.gnt1 && bus.req1;
      tk0 = bus.gnt0 && bus.req0;
      step();
      if (tk1) t1++;
      if (tk0) t0++;
      if (bus.out_valid) got_q.push_back({bus.out_src, bus.out_data});
    end
    check("cap_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("cap_beat%0d", k), 32'(got_q[k]), 32'(exp_q[k]));

    // backpressure: consumer stalls 3 cycles in the middle of A0..A3
    do_reset();
    t0 = 0;
    for (int c = 0; c < 14; c++) begin
      rdy = !(c >= 3 && c <= 5);
      bus.req0 = (t0 < 4); bus.in0 = 8'(8'hA0 + t0); bus.last0 = (t0 == 3);
      bus.req1 = 1'b0; bus.last1 = 1'b0;
      bus.out_ready = rdy;
      if (bus.out_valid && rdy) got8.push_back(bus.out_data);
      prev_v = bus.out_valid;
      prev_d = bus.out_data;
      tk0 = bus.gnt0 && bus.req0 && (!bus.out_valid || rdy);
      step();
      if (tk0) t0++;
      if (!rdy && prev_v)
        check("bp_hold", 32'({bus.out_valid, bus.out_data}), 32'({1'b1, prev_d}));
    end
    check("bp_count", 32'(got8.size()), 32'd4);
    for (int k = 0; k < 4 && k < got8.size(); k++)
      check($sformatf("bp_beat%0d", k), 32'(got8[k]), 32'(8'hA0 + k));

    // reset mid-burst, after requester 0 was served (pointer favours 1)
    do_reset();
    bus.req0 = 1'b1; bus.in0 = 8'hE0; bus.last0 = 1'b1;
    step(); step();
    bus.req0 = 1'b0; bus.last0 = 1'b0;
    step();
    bus.req0 = 1'b1; bus.in0 = 8'hD0;
    step(); step();
    bus.in0 = 8'hD1;
    rst_n = 1'b0;
    step();
    check("rst_mid", 32'({bus.gnt0, bus.gnt1, bus.out_valid, bus.out_src, bus.out_data}), 32'd0);
    rst_n = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    step();
    check("rst_ptr", 32'({bus.gnt0, bus.gnt1}), 32'b10);
    idle_inputs();
    step();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      bus.req0 = ($urandom_range(0, 3) != 0);
      bus.req1 = ($urandom_range(0, 3) != 0);
      bus.in0 = 8'($urandom);
      bus.in1 = 8'($urandom);
      bus.last0 = ($urandom_range(0, 3) == 0);
      bus.last1 = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    rst_n = 1'b1;
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
